// File: rtl/fetch_pkg.sv
// Shared types and defaults for the MIPS instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } pcsel_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection from the held instruction: seq / branch / jump / jump-register.
module next_pc_gen
    import fetch_pkg::*;
#(
    parameter int Abits = 32,
    parameter int Dbits = 32
) (
    input  logic [Abits-1:0] i_pc,
    input  logic [Dbits-1:0] i_instr,
    input  pcsel_t           i_pcsel,
    input  logic [Abits-1:0] i_jr_target,
    output logic [Abits-1:0] o_next_pc,
    output logic             o_misaligned
);

    logic [Abits-1:0] w_pcp4;
    logic [Abits-1:0] w_imm;
    logic             w_unused;

    assign w_pcp4   = i_pc + Abits'(4);
    assign w_imm    = {{(Abits-16){i_instr[15]}}, i_instr[15:0]};
    // Opcode bits are decoded downstream, not here.
    assign w_unused = ^i_instr[Dbits-1:26];

    always_comb begin
        case (i_pcsel)
            PC_SEQ:    o_next_pc = w_pcp4;
            PC_BRANCH: o_next_pc = w_pcp4 + (w_imm << 2);
            PC_JUMP:   o_next_pc = {w_pcp4[Abits-1:28], i_instr[25:0], 2'b00};
            default:   o_next_pc = i_jr_target;
        endcase
    end

    assign o_misaligned = |o_next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ack handshake, held instruction under valid/ready,
// bus-timeout / misaligned-target fault and retired-instruction counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               Abits        = 32,
    parameter int               Dbits        = 32,
    parameter logic [Abits-1:0] RESET_VECTOR = Abits'(RESET_VECTOR_DEFAULT),
    parameter int               TIMEOUT      = 16,
    parameter int               CNTbits      = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [Abits-1:0]   imem_addr,
    input  logic               imem_ack,
    input  logic [Dbits-1:0]   imem_rdata,
    output logic               instr_valid,
    output logic [Dbits-1:0]   instr,
    output logic [Abits-1:0]   pc,
    input  logic               instr_ready,
    input  pcsel_t             pcsel,
    input  logic [Abits-1:0]   jr_target,
    output logic               fault,
    output logic [CNTbits-1:0] instr_count
);

    localparam int TMObits = $clog2(TIMEOUT + 1);

    fetch_state_t       r_state;
    fetch_state_t       w_next_state;
    logic [Abits-1:0]   r_pc;
    logic [Dbits-1:0]   r_instr;
    logic [TMObits-1:0] r_tmo;
    logic               r_fault;
    logic [CNTbits-1:0] r_count;

    logic [Abits-1:0]   w_next_pc;
    logic               w_misaligned;
    logic               w_timeout;
    logic               w_consume;

    next_pc_gen #(
        .Abits (Abits),
        .Dbits (Dbits)
    ) u_next_pc (
        .i_pc         (r_pc),
        .i_instr      (r_instr),
        .i_pcsel      (pcsel),
        .i_jr_target  (jr_target),
        .o_next_pc    (w_next_pc),
        .o_misaligned (w_misaligned)
    );

    assign w_timeout = (r_state == ST_FETCH) && !imem_ack && (r_tmo == TMObits'(TIMEOUT - 1));
    assign w_consume = (r_state == ST_HOLD) && instr_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_FETCH;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: begin
                if (imem_ack)       w_next_state = ST_HOLD;
                else if (w_timeout) w_next_state = ST_HALT;
            end
            ST_HOLD: begin
                if (instr_ready) w_next_state = w_misaligned ? ST_HALT : ST_FETCH;
            end
            default: w_next_state = ST_HALT;
        endcase
    end

    // Request is gated by reset so an assert mid-wait drops it without waiting for a clock.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (r_state)
            ST_FETCH: imem_req    = reset_n;
            ST_HOLD:  instr_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc    <= RESET_VECTOR;
            r_instr <= '0;
            r_tmo   <= '0;
            r_fault <= 1'b0;
            r_count <= '0;
        end else begin
            if (r_state == ST_FETCH) begin
                if (imem_ack) begin
                    r_instr <= imem_rdata;
                    r_tmo   <= '0;
                end else if (w_timeout) begin
                    r_fault <= 1'b1;
                end else begin
                    r_tmo   <= r_tmo + TMObits'(1);
                end
            end
            // A misaligned target still retires the instruction but leaves pc on it.
            if (w_consume) begin
                r_count <= r_count + CNTbits'(1);
                if (w_misaligned) r_fault <= 1'b1;
                else              r_pc    <= w_next_pc;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign fault       = r_fault;
    assign instr_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a table-driven imem responder checks each accepted fetch
// address against a queue of expected addresses; directed checks cover timing and faults.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RV = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_ready = 1'b0;
    pcsel_t      pcsel = PC_SEQ;
    logic [31:0] jr_target = '0;
    logic        fault;
    logic [31:0] instr_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem[logic [31:0]];
    pcsel_t      msel[logic [31:0]];
    logic [31:0] mjr[logic [31:0]];
    int          wait_cfg = 0;
    int          wcnt = 0;
    bit          force_ack = 1'b0;

    fetch_unit #(
        .Abits(32), .Dbits(32), .RESET_VECTOR(RV), .TIMEOUT(16), .CNTbits(32)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .pc(pc), .instr_ready(instr_ready),
        .pcsel(pcsel), .jr_target(jr_target), .fault(fault), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // imem model with configurable wait states; also steers pcsel/jr_target from the held pc.
    always @(negedge clk) begin
        if (force_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            wcnt       = 0;
        end else if (imem_req) begin
            if (wcnt >= wait_cfg) begin
                imem_ack   = 1'b1;
                imem_rdata = mem.exists(imem_addr) ? mem[imem_addr] : 32'h0;
                wcnt       = 0;
                if (exp_q.size() != 0) chk("fetch_addr", imem_addr, exp_q.pop_front());
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end
        pcsel     = msel.exists(pc) ? msel[pc] : PC_SEQ;
        jr_target = mjr.exists(pc) ? mjr[pc] : 32'h0;
    end

    task automatic rst_on();
        @(posedge clk); #2 reset_n = 1'b0;
    endtask

    task automatic rst_off();
        @(posedge clk); #2 reset_n = 1'b1;
    endtask

    task automatic setup(input int wcfg, input bit rdy);
        mem.delete(); msel.delete(); mjr.delete(); exp_q.delete();
        wait_cfg    = wcfg;
        instr_ready = rdy;
    endtask

    task automatic place(input logic [31:0] a, input logic [31:0] w, input pcsel_t s, input logic [31:0] j);
        mem[a] = w; msel[a] = s; mjr[a] = j;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // 1: reset state and zero-wait sequential nops
        rst_on(); setup(0, 1'b1);
        #1;
        chk("rst_req", imem_req, 0);      chk("rst_vld", instr_valid, 0);
        chk("rst_instr", instr, 0);       chk("rst_fault", fault, 0);
        chk("rst_count", instr_count, 0); chk("rst_pc", pc, RV);
        exp_q = '{RV, RV + 4, RV + 8};
        rst_off();
        repeat (6) @(posedge clk);
        #1 chk("t1_count", instr_count, 3);
        drain(10);

        // 2a: backward branch to itself
        rst_on(); setup(0, 1'b1);
        place(RV + 32'h10, 32'h1000_FFFF, PC_BRANCH, 0);
        exp_q = '{RV, RV + 4, RV + 8, RV + 12, RV + 16, RV + 16, RV + 16};
        rst_off(); drain(60);

        // 2b: jump, jump-register, forward branch
        rst_on(); setup(0, 1'b1);
        place(RV,                32'h0810_0040, PC_JUMP,   0);
        place(32'h0040_0100,     32'h03E0_0008, PC_JR,     32'h0040_0200);
        place(32'h0040_0204,     32'h1000_0003, PC_BRANCH, 0);
        exp_q = '{RV, 32'h0040_0100, 32'h0040_0200, 32'h0040_0204, 32'h0040_0214};
        rst_off(); drain(60);

        // 3: three wait states, then backpressure
        rst_on(); setup(3, 1'b0);
        place(RV, 32'h1234_5678, PC_SEQ, 0);
        exp_q = '{RV};
        rst_off();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_req", imem_req, 1); chk("t3_addr", imem_addr, RV); chk("t3_vld0", instr_valid, 0);
        end
        @(negedge clk);
        chk("t3_vld1", instr_valid, 1); chk("t3_instr", instr, 32'h1234_5678); chk("t3_pc", pc, RV);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_vld", instr_valid, 1); chk("t3_hold_pc", pc, RV);
            chk("t3_hold_instr", instr, 32'h1234_5678); chk("t3_hold_req", imem_req, 0);
        end
        exp_q.push_back(RV + 4);
        instr_ready = 1'b1;
        drain(40);
        chk("t3_count", instr_count, 1);

        // 4: bus timeout
        rst_on(); setup(100000, 1'b1);
        rst_off();
        repeat (15) @(posedge clk);
        #1 chk("t4_nofault", fault, 0); chk("t4_req_pre", imem_req, 1);
        @(posedge clk);
        #1 chk("t4_fault", fault, 1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("t4_halt_fault", fault, 1); chk("t4_halt_req", imem_req, 0);
            chk("t4_halt_vld", instr_valid, 0);
        end
        rst_on();
        #1 chk("t4_rst_pc", pc, RV); chk("t4_rst_fault", fault, 0);

        // 5a: misaligned JR target
        setup(0, 1'b1);
        place(RV, 32'h03E0_0008, PC_JR, 32'h0040_0202);
        exp_q = '{RV};
        rst_off(); drain(20);
        repeat (3) @(negedge clk);
        chk("t5_fault", fault, 1);   chk("t5_pc", pc, RV);
        chk("t5_count", instr_count, 1);
        chk("t5_req", imem_req, 0);  chk("t5_vld", instr_valid, 0);

        // 5b: wrap at top of address space
        rst_on(); setup(0, 1'b1);
        place(RV, 32'h03E0_0008, PC_JR, 32'hFFFF_FFFC);
        exp_q = '{RV, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        rst_off(); drain(40);
        chk("t5_wrap_fault", fault, 0);

        // 6: reset mid-wait, late ack while in reset
        rst_on(); setup(5, 1'b0);
        exp_q = '{RV};
        rst_off();
        repeat (2) @(posedge clk);
        #1 chk("t6_req_pre", imem_req, 1);
        rst_on();
        #1 chk("t6_req_rst", imem_req, 0);
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_vld_rst", instr_valid, 0); chk("t6_instr_rst", instr, 0);
        force_ack = 1'b0;
        wait_cfg  = 0;
        rst_off(); drain(20);
        @(negedge clk);
        chk("t6_vld", instr_valid, 1); chk("t6_instr", instr, 0); chk("t6_pc", pc, RV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
